servo_frame_scheduler: RTL and testbench

//   Multi-channel servo PWM controller. Owns the refresh-frame counter (100 MHz clk, 10 ms frame)
//   and time-aligns position updates so that every channel changes pulse width only at a frame

---
 rtl/servo_pkg.sv | 26 ++
 rtl/servo_frame_scheduler_if.sv | 24 ++
 rtl/servo_frame_timer.sv | 75 +++++++
 rtl/servo_frame_scheduler.sv | 115 +++++++++++
 tb/tb_servo_frame_scheduler.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pkg.sv
// Shared types and constants for the servo frame scheduler.
// Optional feature macro used by the top level: SERVO_SLEW_LIMIT_EN.
package servo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int POS_W = 8;
    localparam int CNT_W = 20;

    localparam logic [POS_W-1:0] POS_CENTER = 8'd128;

    // Pulse length in clk cycles for a position, evaluated at counter width.
    function automatic logic [CNT_W-1:0] pulse_cycles(
        input logic [POS_W-1:0] pos,
        input int unsigned      pulse_min,
        input int unsigned      step
    );
        logic [CNT_W-1:0] result;
        result = CNT_W'(pulse_min) + (CNT_W'(pos) * CNT_W'(step));
        return result;
    endfunction

endpackage

// File: rtl/servo_frame_scheduler_if.sv
// Command channel of the servo frame scheduler: valid/ready transfer of
// a channel index and a target position.
interface servo_frame_scheduler_if #(
    parameter int CH_W = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CH_W-1:0] cmd_ch;
    logic [7:0]      cmd_pos;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_pos,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_pos,
        output cmd_ready
    );
endinterface

// File: rtl/servo_frame_timer.sv
// Refresh-frame timer: IDLE/RUN state, the frame counter, the commit strobe
// that marks the wrap edge, and the registered frame_tick.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    output state_t           state,
    output logic [CNT_W-1:0] count,
    output logic             commit,
    output logic             last_cycle,
    output logic             frame_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             tick_reg, tick_next;

    // State, counter and tick registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            tick_reg  <= tick_next;
        end
    end

    // Next-state logic; commit is high in the last RUN cycle so the wrap edge commits.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tick_next  = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                count_next = '0;
                if (en) begin
                    state_next = RUN;
                    tick_next  = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count_reg == LAST) begin
                    count_next = '0;
                    commit     = 1'b1;
                    tick_next  = 1'b1;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign state      = state_reg;
    assign count      = count_reg;
    assign frame_tick = tick_reg;
    assign last_cycle = (state_reg == RUN) && (count_reg == LAST);

endmodule

// File: rtl/servo_frame_scheduler.sv
// Multi-channel servo PWM controller. Position commands land in a pending
// register per channel and are copied to the active register (and its pulse
// compare value) only at the frame wrap, so pulse widths change on frame
// boundaries only.
// Optional feature: define SERVO_SLEW_LIMIT_EN to limit each channel's
// position change to SLEW_STEP per frame.
module servo_frame_scheduler
    import servo_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int FRAME_CYCLES     = 1_000_000,
    parameter int PULSE_MIN_CYCLES = 100_000,
`ifdef SERVO_SLEW_LIMIT_EN
    parameter int SLEW_STEP        = 4,
`endif
    parameter int STEP_CYCLES      = 392
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    en,
    servo_frame_scheduler_if.slave  cmd,
    output logic                    frame_tick,
    output logic [NUM_CH-1:0]       pwm_out
);

    localparam int CH_W = $clog2(NUM_CH);

    localparam logic [CNT_W-1:0] COMPARE_CENTER =
        pulse_cycles(POS_CENTER, PULSE_MIN_CYCLES, STEP_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             commit;
    logic             last_cycle;
    logic             xfer;

    logic [POS_W-1:0] pending_reg [NUM_CH];
    logic [POS_W-1:0] active_reg  [NUM_CH];
    logic [POS_W-1:0] active_next [NUM_CH];
    logic [CNT_W-1:0] compare_reg [NUM_CH];

    servo_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_timer (
        .clk        (clk),
        .clr_n      (clr_n),
        .en         (en),
        .state      (state),
        .count      (count),
        .commit     (commit),
        .last_cycle (last_cycle),
        .frame_tick (frame_tick)
    );

    // Ready drops only in the wrap cycle so a command can never race the commit.
    assign cmd.cmd_ready = ~last_cycle;
    assign xfer          = cmd.cmd_valid && cmd.cmd_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
`ifdef SERVO_SLEW_LIMIT_EN
            localparam logic [POS_W-1:0] SLEW = POS_W'(SLEW_STEP);

            // Move active toward pending by at most SLEW per frame.
            always_comb begin
                active_next[gi] = active_reg[gi];
                if (pending_reg[gi] > active_reg[gi]) begin
                    if ((pending_reg[gi] - active_reg[gi]) > SLEW)
                        active_next[gi] = active_reg[gi] + SLEW;
                    else
                        active_next[gi] = pending_reg[gi];
                end else if (active_reg[gi] > pending_reg[gi]) begin
                    if ((active_reg[gi] - pending_reg[gi]) > SLEW)
                        active_next[gi] = active_reg[gi] - SLEW;
                    else
                        active_next[gi] = pending_reg[gi];
                end
            end
`else
            // Active jumps straight to pending at each commit.
            always_comb begin
                active_next[gi] = pending_reg[gi];
            end
`endif

            // Pending takes the last accepted write; active/compare update at the wrap.
            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    pending_reg[gi] <= POS_CENTER;
                    active_reg[gi]  <= POS_CENTER;
                    compare_reg[gi] <= COMPARE_CENTER;
                end else begin
                    if (xfer && (cmd.cmd_ch == CH_W'(gi)))
                        pending_reg[gi] <= cmd.cmd_pos;
                    if (commit) begin
                        active_reg[gi]  <= active_next[gi];
                        compare_reg[gi] <= pulse_cycles(active_next[gi],
                                                        PULSE_MIN_CYCLES, STEP_CYCLES);
                    end
                end
            end
        end
    endgenerate

    // Registered pulse outputs, one cycle behind the counter.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                pwm_out[i] <= (state == RUN) && (count < compare_reg[i]);
        end
    end

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed bench for servo_frame_scheduler with a shortened frame:
// FRAME=1000, PULSE_MIN=100, STEP=2, so width = 100 + 2*pos (pos 128 -> 356).
module tb_servo_frame_scheduler;

    localparam int NUM_CH = 5;
    localparam int F      = 1000;
    localparam int PMIN   = 100;
    localparam int STEP   = 2;

    logic              clk   = 1'b0;
    logic              clr_n = 1'b0;
    logic              en    = 1'b0;
    logic              frame_tick;
    logic [NUM_CH-1:0] pwm_out;

    servo_frame_scheduler_if #(.CH_W(3)) cmd_if ();

    servo_frame_scheduler #(
        .NUM_CH           (NUM_CH),
        .FRAME_CYCLES     (F),
        .PULSE_MIN_CYCLES (PMIN),
        .STEP_CYCLES      (STEP)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .en         (en),
        .cmd        (cmd_if),
        .frame_tick (frame_tick),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int acc    [NUM_CH];
    int last_w [NUM_CH];
    int exp_w  [NUM_CH];
    int since       = 0;
    int last_period = 0;

    // Per-frame pulse-width and period measurement, sampled mid-cycle.
    always @(negedge clk) begin
        if (!clr_n) begin
            since = 0;
            for (int i = 0; i < NUM_CH; i++) acc[i] = 0;
        end else if (frame_tick) begin
            last_period = since;
            since = 1;
            for (int i = 0; i < NUM_CH; i++) begin
                last_w[i] = acc[i];
                acc[i]    = int'(pwm_out[i]);
            end
        end else begin
            since++;
            for (int i = 0; i < NUM_CH; i++) acc[i] += int'(pwm_out[i]);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Returns in the tick cycle (count 0), after the monitor has latched widths.
    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            cyc(1);
            k++;
        end while (!frame_tick && k < F + 20);
        check("tick_timeout", int'(frame_tick), 1);
        #5;
    endtask

    task automatic check_widths(input string tag);
        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("%s_ch%0d", tag, i), last_w[i], exp_w[i]);
    endtask

    task automatic send(input int ch, input int pos);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 3'(ch);
        cmd_if.cmd_pos   = 8'(pos);
        $display("cmd ch=%0d pos=%0d ready=%0d", ch, pos, cmd_if.cmd_ready);
        check($sformatf("ready_ch%0d", ch), int'(cmd_if.cmd_ready), 1);
        cyc(1);
        cmd_if.cmd_valid = 1'b0;
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ch    = '0;
        cmd_if.cmd_pos   = '0;
        for (int i = 0; i < NUM_CH; i++) exp_w[i] = 356;

        // Reset values
        #12;
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_tick", int'(frame_tick), 0);
        check("rst_ready", int'(cmd_if.cmd_ready), 1);
        cyc(1);
        clr_n = 1'b1;
        cyc(2);
        check("idle_pwm", int'(pwm_out), 0);
        check("idle_tick", int'(frame_tick), 0);

        // Start: tick on first RUN cycle, then a full frame at centre width
        en = 1'b1;
        cyc(1);
        check("first_tick", int'(frame_tick), 1);
        wait_tick();
        check_widths("f1");
        check("f1_period", last_period, F);

`ifdef SERVO_SLEW_LIMIT_EN
        // ch0 128 -> 140 in steps of 4 per frame
        cyc(10);
        send(0, 140);
        wait_tick();
        check_widths("slew_hold");
        exp_w[0] = PMIN + STEP * 132;
        wait_tick();
        check_widths("slew_132");
        exp_w[0] = PMIN + STEP * 136;
        wait_tick();
        check_widths("slew_136");
        exp_w[0] = PMIN + STEP * 140;
        wait_tick();
        check_widths("slew_140");
        wait_tick();
        check_widths("slew_hold140");
`else
        // ch1=0 at count 500: unchanged this frame, 100 next frame
        cyc(500);
        send(1, 0);
        wait_tick();
        check_widths("t2_hold");
        exp_w[1] = 100;
        wait_tick();
        check_widths("t2_new");

        // valid held across count F-1: no transfer there, accepted at count 0
        cyc(F - 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_ch    = 3'd3;
        cmd_if.cmd_pos   = 8'd255;
        $display("cmd ch=3 pos=255 held at last cycle ready=%0d", cmd_if.cmd_ready);
        check("t3_ready_last", int'(cmd_if.cmd_ready), 0);
        cyc(1);
        check("t3_tick", int'(frame_tick), 1);
        check("t3_ready_zero", int'(cmd_if.cmd_ready), 1);
        cyc(1);
        cmd_if.cmd_valid = 1'b0;
        wait_tick();
        check_widths("t3_hold");
        exp_w[3] = 610;
        wait_tick();
        check_widths("t3_new");

        // two writes to ch2 in one frame: the last one wins
        cyc(100);
        send(2, 10);
        cyc(100);
        send(2, 200);
        wait_tick();
        check_widths("t4_hold");
        exp_w[2] = 500;
        wait_tick();
        check_widths("t4_new");

        // write in the last ready cycle (count F-2) commits at the next wrap
        cyc(F - 2);
        send(0, 50);
        wait_tick();
        check_widths("t5_hold");
        exp_w[0] = 200;
        wait_tick();
        check_widths("t5_new");

        // out-of-range channel is accepted and dropped
        cyc(10);
        send(7, 0);
        wait_tick();
        check_widths("oor_hold");
        wait_tick();
        check_widths("oor_after");

        // en drop mid-pulse, then restart from count 0
        cyc(50);
        check("en_pwm_high", int'(pwm_out), 5'b11111);
        en = 1'b0;
        cyc(2);
        check("en_pwm_low", int'(pwm_out), 0);
        check("en_ready", int'(cmd_if.cmd_ready), 1);
        cyc(5);
        check("en_idle_pwm", int'(pwm_out), 0);
        check("en_idle_tick", int'(frame_tick), 0);
        en = 1'b1;
        cyc(1);
        check("restart_tick", int'(frame_tick), 1);
        wait_tick();
        check("restart_period", last_period, F);
        check_widths("restart");
`endif

        // Async reset mid-frame: outputs drop at once, pending write lost
        cyc(20);
        send(4, 0);
        cyc(10);
        check("ar_pwm_high", int'(pwm_out), 5'b11111);
        clr_n = 1'b0;
        #1;
        check("ar_pwm", int'(pwm_out), 0);
        check("ar_tick", int'(frame_tick), 0);
        check("ar_ready", int'(cmd_if.cmd_ready), 1);
        cyc(2);
        clr_n = 1'b1;
        for (int i = 0; i < NUM_CH; i++) exp_w[i] = 356;
        cyc(1);
        check("ar_restart_tick", int'(frame_tick), 1);
        wait_tick();
        check_widths("ar_f1");
        check("ar_period", last_period, F);
        wait_tick();
        check_widths("ar_f2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
